mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, data/address width of every bus port.
REQ-002 Parameter BUS_TAG_WIDTH, default 13, tag width of every bus port.
REQ-003 Parameter BEATS, default 8, response beats per granted transaction.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 c_reqcyc  input  2  per-client request valid; bit i = client i.
REQ-007 c_reqack  output  2  per-client request acknowledge.
REQ-008 c_req  input  2*BUS_DATA_WIDTH  request address; client i at [i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH].
REQ-009 c_reqtag  input  2*BUS_TAG_WIDTH  request tag; same packing.
REQ-010 c_respcyc  output  2  per-client response valid.
REQ-011 c_respack  input  2  per-client response acknowledge.
REQ-012 c_resp  output  BUS_DATA_WIDTH  response data, shared by both clients.
REQ-013 c_resptag  output  BUS_TAG_WIDTH  response tag, shared by both clients.
REQ-014 m_bus_reqcyc / m_bus_reqack / m_bus_req / m_bus_reqtag  out/in/out/out  1/1/BUS_DATA_WIDTH/BUS_TAG_WIDTH  memory request channel.
REQ-015 m_bus_respcyc / m_bus_respack / m_bus_resp / m_bus_resptag  in/out/in/in  1/1/BUS_DATA_WIDTH/BUS_TAG_WIDTH  memory response channel.
REQ-016 grant_valid  output  1  high in REQ and RESP states.
REQ-017 grant_id  output  1  owning client index; 0 when grant_valid low.

Function
REQ-018 Block SHALL share one memory bus between two clients (e.g. icache, dcache), one transaction at a time.
REQ-019 State machine SHALL have exactly IDLE, REQ and RESP states.
REQ-020 IDLE: if any c_reqcyc bit high, SHALL register winner into grant and move to REQ next cycle; no outputs asserted in IDLE.
REQ-021 Arbitration SHALL be round-robin: single requester wins; if both request, the client not granted last wins; after reset, client 0 has priority.
REQ-022 REQ: m_bus_reqcyc=1, m_bus_req/m_bus_reqtag = granted client's c_req/c_reqtag; c_reqack[grant] = m_bus_reqack combinationally.
REQ-023 REQ: on m_bus_reqack=1, SHALL clear beat counter and enter RESP next cycle.
REQ-024 Clients SHALL hold c_reqcyc and c_req stable until c_reqack; arbiter SHALL NOT re-arbitrate in REQ or RESP.
REQ-025 RESP: c_respcyc[grant] = m_bus_respcyc, c_resp = m_bus_resp, c_resptag = m_bus_resptag, m_bus_respack = c_respack[grant], all combinational.
REQ-026 Beat counter ($clog2(BEATS) bits) SHALL increment on each cycle with m_bus_respcyc and c_respack[grant] both high.
REQ-027 On handshake of beat BEATS-1 SHALL return to IDLE, record grant as last granted; next request accepted earliest the following cycle.
REQ-028 Non-granted client SHALL see c_reqack=0 and c_respcyc=0 at all times.
REQ-029 Response-channel outputs SHALL be 0 outside RESP; m_bus_respack=0 outside RESP.
REQ-030 m_bus_respcyc outside RESP SHALL be ignored (no ack, no count).
REQ-031 Request from the losing client SHALL remain pending, served after the current transaction without being dropped.

Reset
REQ-032 reset SHALL force IDLE, beat counter 0, priority to client 0, grant 0.
REQ-033 During reset and the cycle after, all outputs SHALL be 0.
REQ-034 reset mid-REQ or mid-RESP SHALL abandon the transaction immediately; no further ack or respcyc to any client.

Verification
REQ-035 Only client 1 requests addr 0x1000 tag 5 -> REQ next cycle, m_bus_req=0x1000, m_bus_reqtag=5; c_reqack=2'b10 on mem ack.
REQ-036 Both request in same cycle after reset -> client 0 served 8 beats, then client 1 granted without re-request; grant_id 0 then 1.
REQ-037 Client 0 requests back-to-back while client 1 waits -> grants alternate 0,1,0.
REQ-038 Memory sends 8 beats, client 0 stalls c_respack on beat 3 for 4 cycles -> beat held, m_bus_respack=0, counter stays 3, exactly 8 acked beats.
REQ-039 reset asserted at beat 4 of RESP -> IDLE next cycle, all outputs 0, counter 0, client 0 priority.
REQ-040 m_bus_respcyc pulsed while IDLE -> no c_respcyc, no m_bus_respack, state stays IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one burst memory bus between two clients
module mem_bus_arbiter #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS          = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  c_reqcyc,
   output logic [1:0]                  c_reqack,
   input  logic [2*BUS_DATA_WIDTH-1:0] c_req,
   input  logic [2*BUS_TAG_WIDTH-1:0]  c_reqtag,
   output logic [1:0]                  c_respcyc,
   input  logic [1:0]                  c_respack,
   output logic [BUS_DATA_WIDTH-1:0]   c_resp,
   output logic [BUS_TAG_WIDTH-1:0]    c_resptag,
   output logic                        m_bus_reqcyc,
   input  logic                        m_bus_reqack,
   output logic [BUS_DATA_WIDTH-1:0]   m_bus_req,
   output logic [BUS_TAG_WIDTH-1:0]    m_bus_reqtag,
   input  logic                        m_bus_respcyc,
   output logic                        m_bus_respack,
   input  logic [BUS_DATA_WIDTH-1:0]   m_bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]    m_bus_resptag,
   output logic                        grant_valid,
   output logic                        grant_id
);
   localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t        state, state_next;
   logic          grant, prio, winner, act_req, act_resp, beat_hs, last_beat;
   logic [CW-1:0] beat;
   // prio names the client that wins a tie; it flips to the other client after each transaction
   assign winner    = &c_reqcyc ? prio : c_reqcyc[1];
   // outputs are forced quiet while reset is high, even before the state register clears
   assign act_req   = !reset && state == REQ;
   assign act_resp  = !reset && state == RESP;
   assign beat_hs   = act_resp && m_bus_respcyc && c_respack[grant];
   assign last_beat = beat == CW'(BEATS - 1);
   // state, grant owner, tie-break priority and beat counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grant <= 1'b0;
         prio  <= 1'b0;
         beat  <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && |c_reqcyc) grant <= winner;
         if (act_req && m_bus_reqack) beat <= '0;
         else if (beat_hs) beat <= beat + 1'b1;
         if (beat_hs && last_beat) prio <= ~grant;
      end
   end
   // next-state: arbitrate only in IDLE, then hold the owner through request and burst
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (|c_reqcyc) state_next = REQ;
         REQ:     if (m_bus_reqack) state_next = RESP;
         RESP:    if (beat_hs && last_beat) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end
   // steer the owner's request onto the bus and the bus response back to the owner only
   always_comb begin
      c_reqack           = '0;
      c_respcyc          = '0;
      c_reqack[grant]    = act_req && m_bus_reqack;
      c_respcyc[grant]   = act_resp && m_bus_respcyc;
      m_bus_reqcyc       = act_req;
      m_bus_req          = !act_req ? '0 : grant ? c_req[BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : c_req[0 +: BUS_DATA_WIDTH];
      m_bus_reqtag       = !act_req ? '0 : grant ? c_reqtag[BUS_TAG_WIDTH +: BUS_TAG_WIDTH] : c_reqtag[0 +: BUS_TAG_WIDTH];
      c_resp             = act_resp ? m_bus_resp : '0;
      c_resptag          = act_resp ? m_bus_resptag : '0;
      m_bus_respack      = act_resp && c_respack[grant];
      grant_valid        = act_req || act_resp;
      grant_id           = grant_valid && grant;
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_bus_arbiter;
   localparam int DW = 64;
   localparam int TW = 13;
   localparam int B  = 8;
   localparam int OW = 2 + 2 + DW + TW + 1 + DW + TW + 1 + 1 + 1;
   logic              clk = 0, reset = 1;
   logic [1:0]        c_reqcyc = '0, c_respack = '0, c_reqack, c_respcyc;
   logic [2*DW-1:0]   c_req = '0;
   logic [2*TW-1:0]   c_reqtag = '0;
   logic [DW-1:0]     c_resp, m_bus_req, m_bus_resp = '0;
   logic [TW-1:0]     c_resptag, m_bus_reqtag, m_bus_resptag = '0;
   logic              m_bus_reqcyc, m_bus_reqack = 0, m_bus_respcyc = 0, m_bus_respack;
   logic              grant_valid, grant_id;
   logic [OW-1:0]     all_out;
   int                n_cmp = 0, n_err = 0;

   assign all_out = {c_reqack, c_respcyc, c_resp, c_resptag, m_bus_reqcyc, m_bus_req, m_bus_reqtag,
                     m_bus_respack, grant_valid, grant_id};

   always #5 clk = ~clk;

   mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(B)) dut (
      .clk(clk), .reset(reset),
      .c_reqcyc(c_reqcyc), .c_reqack(c_reqack), .c_req(c_req), .c_reqtag(c_reqtag),
      .c_respcyc(c_respcyc), .c_respack(c_respack), .c_resp(c_resp), .c_resptag(c_resptag),
      .m_bus_reqcyc(m_bus_reqcyc), .m_bus_reqack(m_bus_reqack), .m_bus_req(m_bus_req), .m_bus_reqtag(m_bus_reqtag),
      .m_bus_respcyc(m_bus_respcyc), .m_bus_respack(m_bus_respack), .m_bus_resp(m_bus_resp), .m_bus_resptag(m_bus_resptag),
      .grant_valid(grant_valid), .grant_id(grant_id)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      c_reqcyc = '0; c_respack = '0; m_bus_reqack = 0; m_bus_respcyc = 0; m_bus_resp = '0; m_bus_resptag = '0;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1;
      tick();
      tick();
      reset = 0;
      tick();
   endtask

   task automatic set_req(input int c, input logic [DW-1:0] a, input logic [TW-1:0] t);
      c_req[c*DW +: DW] = a;
      c_reqtag[c*TW +: TW] = t;
      c_reqcyc[c] = 1'b1;
   endtask

   task automatic do_req_ack(input int c);
      m_bus_reqack = 1;
      tick();
      m_bus_reqack = 0;
      c_reqcyc[c] = 1'b0;
   endtask

   task automatic finish_txn(input int c, output int n);
      n = 0;
      for (int i = 0; i < B; i++) begin
         m_bus_respcyc = 1;
         m_bus_resp = {$urandom, $urandom};
         c_respack = 2'(1 << c);
         #1;
         if (c_respcyc[c] && m_bus_respack) n++;
         tick();
      end
      m_bus_respcyc = 0;
      c_respack = '0;
   endtask

   task automatic test_reset();
      reset = 1;
      c_reqcyc = 2'b11; m_bus_reqack = 1; m_bus_respcyc = 1; c_respack = 2'b11;
      tick();
      #1;
      n_cmp++;
      if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
      tick();
      reset = 0;
      idle_in();
      #1;
      n_cmp++;
      if (all_out !== '0) begin n_err++; $display("FAIL after_reset_outputs: got %h want 0", all_out); end
      tick();
   endtask

   task automatic test_single();
      int n;
      set_req(1, 64'h1000, 13'd5);
      #1;
      n_cmp++;
      if (grant_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_gv: got %b want 0", grant_valid); end
      tick();
      n_cmp++;
      if ({grant_valid, grant_id, m_bus_reqcyc} !== 3'b111) begin n_err++; $display("FAIL single_req_state: got %b want 111", {grant_valid, grant_id, m_bus_reqcyc}); end
      n_cmp++;
      if ({m_bus_req, m_bus_reqtag} !== {64'h1000, 13'd5}) begin n_err++; $display("FAIL single_req_fwd: got %h/%h want 1000/5", m_bus_req, m_bus_reqtag); end
      n_cmp++;
      if (c_reqack !== 2'b00) begin n_err++; $display("FAIL single_noack: got %b want 00", c_reqack); end
      m_bus_reqack = 1;
      #1;
      n_cmp++;
      if (c_reqack !== 2'b10) begin n_err++; $display("FAIL single_ack: got %b want 10", c_reqack); end
      tick();
      m_bus_reqack = 0;
      c_reqcyc = '0;
      finish_txn(1, n);
      n_cmp++;
      if (n != B || grant_valid !== 1'b0) begin n_err++; $display("FAIL single_beats: got %0d beats gv=%b want %0d gv=0", n, grant_valid, B); end
   endtask

   task automatic test_both();
      int n;
      do_reset();
      set_req(0, 64'hA000, 13'd1);
      set_req(1, 64'hB000, 13'd2);
      tick();
      n_cmp++;
      if ({grant_valid, grant_id, m_bus_req} !== {2'b10, 64'hA000}) begin n_err++; $display("FAIL both_first: got %b%b %h want 10 a000", grant_valid, grant_id, m_bus_req); end
      do_req_ack(0);
      finish_txn(0, n);
      n_cmp++;
      if (n != B || grant_valid !== 1'b0) begin n_err++; $display("FAIL both_beats0: got %0d gv=%b want %0d gv=0", n, grant_valid, B); end
      tick();
      n_cmp++;
      if ({grant_valid, grant_id, m_bus_req} !== {2'b11, 64'hB000}) begin n_err++; $display("FAIL both_second: got %b%b %h want 11 b000", grant_valid, grant_id, m_bus_req); end
      do_req_ack(1);
      finish_txn(1, n);
   endtask

   task automatic test_back_to_back();
      int n, c;
      int exp_g[3] = '{0, 1, 0};
      do_reset();
      set_req(0, 64'h10, 13'd3);
      set_req(1, 64'h20, 13'd4);
      for (int t = 0; t < 3; t++) begin
         for (int k = 0; k < 4 && !grant_valid; k++) tick();
         n_cmp++;
         if ({grant_valid, grant_id} !== {1'b1, 1'(exp_g[t])}) begin n_err++; $display("FAIL b2b_grant%0d: got %b%b want 1%0d", t, grant_valid, grant_id, exp_g[t]); end
         c = int'(grant_id);
         do_req_ack(c);
         c_reqcyc[0] = (t < 2);
         finish_txn(c, n);
      end
   endtask

   task automatic test_stall();
      logic [DW-1:0] d[B];
      int n = 0, stall = 0;
      bit stalling, exp_ack;
      for (int i = 0; i < B; i++) d[i] = {$urandom, $urandom};
      do_reset();
      set_req(0, 64'h300, 13'd7);
      tick();
      do_req_ack(0);
      for (int cyc = 0; cyc < 40 && n < B; cyc++) begin
         stalling = (n == 3 && stall < 4);
         m_bus_respcyc = 1;
         m_bus_resp = d[n];
         m_bus_resptag = 13'd7;
         c_respack = stalling ? 2'b00 : 2'b01;
         exp_ack = !stalling;
         #1;
         n_cmp++;
         if ({m_bus_respack, c_respcyc, c_resp} !== {exp_ack, 2'b01, d[n]}) begin
            n_err++;
            $display("FAIL stall_beat%0d: got ack=%b cyc=%b %h want ack=%b cyc=01 %h", n, m_bus_respack, c_respcyc, c_resp, exp_ack, d[n]);
         end
         if (stalling) stall++;
         else n++;
         tick();
      end
      idle_in();
      #1;
      n_cmp++;
      if (n != B || stall != 4 || grant_valid !== 1'b0) begin n_err++; $display("FAIL stall_total: got %0d beats %0d stalls gv=%b want %0d 4 0", n, stall, grant_valid, B); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(1, 64'h400, 13'd9);
      tick();
      do_req_ack(1);
      for (int b = 0; b < 4; b++) begin
         m_bus_respcyc = 1;
         c_respack = 2'b10;
         tick();
      end
      reset = 1;
      #1;
      n_cmp++;
      if (all_out !== '0) begin n_err++; $display("FAIL midreset_during: got %h want 0", all_out); end
      tick();
      reset = 0;
      set_req(0, 64'h500, 13'd1);
      set_req(1, 64'h600, 13'd2);
      c_respack = 2'b11;
      #1;
      n_cmp++;
      if (all_out !== '0) begin n_err++; $display("FAIL midreset_after: got %h want 0", all_out); end
      tick();
      n_cmp++;
      if ({grant_valid, grant_id, c_respcyc, m_bus_respack} !== 5'b10000) begin
         n_err++;
         $display("FAIL midreset_prio: got %b want 10000", {grant_valid, grant_id, c_respcyc, m_bus_respack});
      end
      do_reset();
   endtask

   task automatic test_idle_respcyc();
      int n;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         m_bus_respcyc = 1;
         c_respack = 2'b11;
         m_bus_resp = {$urandom, $urandom};
         #1;
         n_cmp++;
         if ({c_respcyc, m_bus_respack, grant_valid, c_resp} !== '0) begin
            n_err++;
            $display("FAIL idle_respcyc%0d: got %b %b %b %h want all 0", k, c_respcyc, m_bus_respack, grant_valid, c_resp);
         end
         tick();
      end
      idle_in();
      set_req(0, 64'h700, 13'd6);
      tick();
      do_req_ack(0);
      finish_txn(0, n);
      n_cmp++;
      if (n != B) begin n_err++; $display("FAIL idle_then_beats: got %0d want %0d", n, B); end
   endtask

   task automatic test_random();
      bit            pend[2] = '{0, 0};
      logic [DW-1:0] ad[2];
      logic [TW-1:0] tg[2];
      int            owner = -1, last = 1, nb = 0, done = 0, oi;
      bit            acked = 0, rq, rs;
      logic [1:0]    e_gnt, oh, e_reqack, e_respcyc;
      logic [DW-1:0] e_mreq, e_resp;
      logic [TW-1:0] e_mtag, e_rtag;
      logic          e_mrespack;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(3) == 0) begin
               pend[i] = 1;
               ad[i] = {$urandom, $urandom};
               tg[i] = TW'($urandom);
               c_req[i*DW +: DW] = ad[i];
               c_reqtag[i*TW +: TW] = tg[i];
            end
            c_reqcyc[i] = pend[i];
         end
         m_bus_reqack = 1'($urandom_range(1));
         m_bus_respcyc = $urandom_range(4) != 0;
         m_bus_resp = {$urandom, $urandom};
         m_bus_resptag = TW'($urandom);
         c_respack = $urandom_range(3) != 0 ? 2'b11 : 2'($urandom);
         #1;
         oi = owner < 0 ? 0 : owner;
         oh = 2'(1 << oi);
         rq = owner >= 0 && !acked;
         rs = owner >= 0 && acked;
         e_gnt = owner < 0 ? 2'b00 : {1'b1, owner == 1};
         e_mreq = rq ? ad[oi] : '0;
         e_mtag = rq ? tg[oi] : '0;
         e_reqack = rq && m_bus_reqack ? oh : 2'b00;
         e_respcyc = rs && m_bus_respcyc ? oh : 2'b00;
         e_resp = rs ? m_bus_resp : '0;
         e_rtag = rs ? m_bus_resptag : '0;
         e_mrespack = rs && c_respack[oi];
         n_cmp++;
         if ({grant_valid, grant_id} !== e_gnt) begin n_err++; $display("FAIL rnd_grant@%0d: got %b%b want %b", cyc, grant_valid, grant_id, e_gnt); end
         n_cmp++;
         if ({m_bus_reqcyc, m_bus_req, m_bus_reqtag, c_reqack} !== {rq, e_mreq, e_mtag, e_reqack}) begin
            n_err++;
            $display("FAIL rnd_req@%0d: got %b %h %h %b want %b %h %h %b", cyc, m_bus_reqcyc, m_bus_req, m_bus_reqtag, c_reqack, rq, e_mreq, e_mtag, e_reqack);
         end
         n_cmp++;
         if ({c_respcyc, c_resp, c_resptag, m_bus_respack} !== {e_respcyc, e_resp, e_rtag, e_mrespack}) begin
            n_err++;
            $display("FAIL rnd_resp@%0d: got %b %h %h %b want %b %h %h %b", cyc, c_respcyc, c_resp, c_resptag, m_bus_respack, e_respcyc, e_resp, e_rtag, e_mrespack);
         end
         if (owner < 0) begin
            if (pend[0] || pend[1]) begin
               owner = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
               acked = 0;
            end
         end else if (!acked) begin
            if (m_bus_reqack) begin acked = 1; nb = 0; pend[owner] = 0; end
         end else if (m_bus_respcyc && c_respack[owner]) begin
            nb++;
            if (nb == B) begin last = owner; owner = -1; done++; end
         end
         tick();
      end
      idle_in();
      n_cmp++;
      if (done < 20) begin n_err++; $display("FAIL rnd_progress: got %0d transactions want >= 20", done); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_both();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_idle_respcyc();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
